add_sequencer: RTL and testbench

Multi-cycle 8-bit add/subtract sequencer that owns the single 4-bit carry-lookahead adder in the datapath. It arbitrates round-robin between two requesters and steps the adder through the operand one nibble per cycle, carrying through a registered carry. It returns the full-width result with a one-cycle done pulse to the winning requester.

---
 rtl/add_sequencer_if.sv | 28 ++
 rtl/add_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_add_sequencer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/add_sequencer_if.sv
// ============================================================================
// Module      : add_sequencer_if
// Description : Nibble-wide bus between add_sequencer and the shared 4-bit
//               carry-lookahead adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface add_sequencer_if;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic       add_en;
    logic [3:0] add_sum;
    logic       add_cout;

    modport master (
        output add_a, add_b, add_cin, add_en,
        input  add_sum, add_cout
    );

    modport slave (
        input  add_a, add_b, add_cin, add_en,
        output add_sum, add_cout
    );
endinterface

`default_nettype wire

// File: rtl/add_sequencer.sv
// ============================================================================
// Module      : add_sequencer
// Description : Two-requester round-robin add/subtract sequencer driving a
//               shared 4-bit adder one nibble per cycle. Define ADDSEQ_OVF_EN
//               to build the signed-overflow flag (ovf is tied 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_sequencer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [1:0]       req,
    input  wire logic [WIDTH-1:0] a0,
    input  wire logic [WIDTH-1:0] b0,
    input  wire logic             sub0,
    input  wire logic [WIDTH-1:0] a1,
    input  wire logic [WIDTH-1:0] b1,
    input  wire logic             sub1,
    output logic [1:0]            gnt,
    output logic [1:0]            done,
    output logic                  busy,
    output logic [WIDTH-1:0]      result,
    output logic                  cout,
    output logic                  ovf,
    add_sequencer_if.master       adder
);

    localparam int c_NIB   = WIDTH / 4;
    localparam int c_IDX_W = (c_NIB > 1) ? $clog2(c_NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_carry;
    logic               r_owner;
    logic               r_rr;
    logic               r_cout;
    logic               w_start;
    logic               w_winner;
    logic               w_last;
    logic               w_sel_sub;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [WIDTH-1:0]   w_res_full;
    logic [1:0]         w_owner_oh;

    // Round-robin pointer only matters when both requesters collide.
    assign w_winner   = (req == 2'b11) ? r_rr : req[1];
    assign w_sel_a    = w_winner ? a1 : a0;
    assign w_sel_b    = w_winner ? b1 : b0;
    assign w_sel_sub  = w_winner ? sub1 : sub0;
    assign w_last     = (r_idx == c_IDX_W'(c_NIB - 1));
    assign w_owner_oh = {r_owner, ~r_owner};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        busy         = 1'b0;
        gnt          = 2'b00;
        done         = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_start      = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                gnt  = w_owner_oh;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                gnt          = w_owner_oh;
                done         = w_owner_oh;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Nibble select toward the adder, and merge of its sum into the accumulator.
    always_comb begin
        adder.add_a   = 4'd0;
        adder.add_b   = 4'd0;
        adder.add_cin = 1'b0;
        adder.add_en  = 1'b0;
        w_res_full    = r_acc;
        if (r_state == S_RUN) begin
            adder.add_cin = r_carry;
            adder.add_en  = 1'b1;
            for (int n = 0; n < c_NIB; n++) begin
                if (r_idx == c_IDX_W'(n)) begin
                    adder.add_a         = r_a[n*4 +: 4];
                    adder.add_b         = r_b[n*4 +: 4];
                    w_res_full[n*4 +: 4] = adder.add_sum;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_owner  <= 1'b0;
            r_rr     <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            if (w_start) begin
                r_a     <= w_sel_a;
                r_b     <= w_sel_sub ? ~w_sel_b : w_sel_b;
                r_carry <= w_sel_sub;
                r_owner <= w_winner;
                r_idx   <= '0;
            end
            if (r_state == S_RUN) begin
                r_acc   <= w_res_full;
                r_carry <= adder.add_cout;
                r_idx   <= r_idx + 1'b1;
                if (w_last) begin
                    r_result <= w_res_full;
                    r_cout   <= adder.add_cout;
                end
            end
            if (r_state == S_DONE) begin
                r_rr <= ~r_owner;
            end
        end
    end

`ifdef ADDSEQ_OVF_EN
    logic r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_ovf <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                     (w_res_full[WIDTH-1] != r_a[WIDTH-1]);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign result = r_result;
    assign cout   = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_add_sequencer.sv
// ============================================================================
// Module      : tb_add_sequencer
// Description : Directed-vector scoreboard bench for add_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_add_sequencer;

    localparam int WIDTH = 8;
`ifdef ADDSEQ_OVF_EN
    localparam bit c_OVF_ON = 1'b1;
`else
    localparam bit c_OVF_ON = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req   = 2'b00;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             sub0 = 1'b0, sub1 = 1'b0;
    logic [1:0]       gnt, done;
    logic             busy, cout, ovf;
    logic [WIDTH-1:0] result;
    logic [4:0]       w_model;

    typedef struct packed {
        logic [1:0] oh;
        logic [7:0] res;
        logic       co;
        logic       ov;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    add_sequencer_if u_add ();

    // Behavioural stand-in for the shared 4-bit adder.
    assign w_model = u_add.add_en ?
        ({1'b0, u_add.add_a} + {1'b0, u_add.add_b} + {4'd0, u_add.add_cin}) : 5'd0;
    assign u_add.add_sum  = w_model[3:0];
    assign u_add.add_cout = w_model[4];

    add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a0     (a0),
        .b0     (b0),
        .sub0   (sub0),
        .a1     (a1),
        .b1     (b1),
        .sub1   (sub1),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .adder  (u_add)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (done != 2'b00)) begin
            if (sb.size() == 0) begin
                check("spurious_done", {30'd0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_owner", {30'd0, done}, {30'd0, e.oh});
                check("result", {24'd0, result}, {24'd0, e.res});
                check("cout", {31'd0, cout}, {31'd0, e.co});
                check("ovf", {31'd0, ovf}, {31'd0, e.ov});
            end
        end
    end

    task automatic expect_op(input int who, input logic [7:0] er, input logic ec, input logic eo);
        exp_t e;
        e.oh  = (who == 0) ? 2'b01 : 2'b10;
        e.res = er;
        e.co  = ec;
        e.ov  = eo & c_OVF_ON;
        sb.push_back(e);
    endtask

    // Called just after the grant edge; follows the operation to IDLE.
    task automatic serve(input int who, input bit drop_early);
        int         cyc  = 0;
        bit         seen = 1'b0;
        logic [1:0] oh   = (who == 0) ? 2'b01 : 2'b10;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && drop_early) req[who] = 1'b0;
            if (cyc <= 3) begin
                check("gnt_active", {30'd0, gnt}, {30'd0, oh});
                check("busy_active", {31'd0, busy}, 32'd1);
            end
            if (cyc <= 2) check("add_en_run", {31'd0, u_add.add_en}, 32'd1);
            if (done != 2'b00) seen = 1'b1;
        end
        check("done_cycle", cyc, 32'd3);
        req[who] = 1'b0;
        @(negedge clk);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_gnt", {30'd0, gnt}, 32'd0);
        check("idle_adder", {22'd0, u_add.add_a, u_add.add_b, u_add.add_cin, u_add.add_en}, 32'd0);
    endtask

    task automatic run_op(input int who, input logic [7:0] a, input logic [7:0] b, input logic sub,
                          input logic [7:0] er, input logic ec, input logic eo, input bit drop_early);
        @(negedge clk);
        if (who == 0) begin a0 = a; b0 = b; sub0 = sub; end
        else          begin a1 = a; b1 = b; sub1 = sub; end
        req[who] = 1'b1;
        expect_op(who, er, ec, eo);
        @(posedge clk);
        serve(who, drop_early);
    endtask

    initial begin
        int         n_done;
        int         cyc;
        int         cyc_log[3];
        logic [1:0] own_log[3];

        // Both requesters held from reset: expected order 0, 1, 0.
        req = 2'b11;
        a0 = 8'h11; b0 = 8'h22; sub0 = 1'b0;
        a1 = 8'h50; b1 = 8'h30; sub1 = 1'b1;
        expect_op(0, 8'h33, 1'b0, 1'b0);
        expect_op(1, 8'h20, 1'b1, 1'b0);
        expect_op(0, 8'h33, 1'b0, 1'b0);

        @(negedge clk);
        check("rst_outputs", {22'd0, gnt, done, busy, cout, ovf, u_add.add_en, u_add.add_cin, 1'b0},
              32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_adder_ops", {24'd0, u_add.add_a, u_add.add_b}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        n_done = 0;
        cyc    = 0;
        while (n_done < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (done != 2'b00) begin
                cyc_log[n_done] = cyc;
                own_log[n_done] = done;
                n_done++;
                if (n_done == 3) req = 2'b00;
            end
        end
        check("contention_count", n_done, 32'd3);
        if (n_done == 3) begin
            check("cont_first_cycle", cyc_log[0], 32'd3);
            check("cont_first_owner", {30'd0, own_log[0]}, 32'd1);
            check("cont_second_cycle", cyc_log[1], 32'd7);
            check("cont_second_owner", {30'd0, own_log[1]}, 32'd2);
            check("cont_third_cycle", cyc_log[2], 32'd11);
            check("cont_third_owner", {30'd0, own_log[2]}, 32'd1);
        end
        @(negedge clk);
        check("cont_idle_busy", {31'd0, busy}, 32'd0);

        run_op(0, 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0);
        run_op(1, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
        run_op(1, 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op(0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);

        // Reset in the second RUN cycle, then re-serve the held request.
        @(negedge clk);
        a0 = 8'h55; b0 = 8'h0A; sub0 = 1'b0;
        req[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_gnt", {30'd0, gnt}, 32'd0);
        check("rstmid_result", {24'd0, result}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("rstmid_no_done", {30'd0, done}, 32'd0);
        end
        expect_op(0, 8'h5F, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        serve(0, 1'b0);

        // Requester drops req right after the grant.
        run_op(0, 8'h99, 8'h66, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
